ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
// - AHB-Lite responder that pairs with AHB_Master. It serves single transfers and
//   burst beats into a local word-addressed SRAM.
// - Sits on the slave side of the bus, behind the decoder (HSEL) and the HREADY mux.
// - Supports programmable wait states, byte/halfword/word lanes and two-cycle ERROR
//   responses for illegal accesses.
// PARAMETERS
// - MEM_DEPTH    256  number of 32-bit words; must be a power of 2; addressed by HADDR[AW+1:2]
// - WAIT_STATES  0    HREADYOUT-low cycles inserted before every OKAY data phase (0..15)
// - BASE_ADDR    32'h0000_0000  base of slave window; offsets >= MEM_DEPTH*4 -> ERROR
// PORTS
// - HCLK       in   1   bus clock, all state on rising edge
// - HRESETn    in   1   asynchronous active-low reset
// - HSEL       in   1   slave select from address decoder
// - HADDR      in   32  address-phase address
// - HWRITE     in   1   1=write, 0=read (address phase)
// - HSIZE      in   HSIZE_E   BYTE/HALFWORD/WORD; larger encodings -> ERROR
// - HBURST     in   HBURST_E  accepted; no effect on the response
// - HTRANS     in   HTRANS_E  IDLE/BUSY/NONSEQ/SEQ
// - HWDATA     in   32  write data, valid in data phase
// - HREADY     in   1   bus HREADY (mux output); qualifies the address phase
// - HREADYOUT  out  1   this slave's ready
// - HRESP      out  HRESP_E   OKAY/ERROR
// - HRDATA     out  32  read data
// BEHAVIOUR
// - Reset: state=ST_IDLE, HREADYOUT=1, HRESP=OKAY, HRDATA=0, wait counter=0.
//   SRAM contents are not reset.
// - Address phase accepted at a rising edge iff HSEL & HREADY & HTRANS in {NONSEQ,SEQ}.
//   On acceptance, register addr_q, write_q, size_q.
// - IDLE/BUSY, or HSEL=0 with HREADY=1: next cycle is zero-wait OKAY. No SRAM access.
// - Illegal access, decided at acceptance:
//   * offset out of range
//   * HSIZE > WORD
//   * HALFWORD with HADDR[0]=1
//   * WORD with HADDR[1:0]!=0
// - FSM states: ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2.
//   * ST_IDLE, legal accept: WAIT_STATES=0 -> complete next cycle (stay/enter ST_IDLE
//     as the data-phase owner). Otherwise -> ST_WAIT with cnt=WAIT_STATES.
//   * ST_WAIT: HREADYOUT=0, HRESP=OKAY, cnt decrements. At cnt==1, next cycle is the
//     completing data phase (HREADYOUT=1).
//   * Illegal accept -> ST_ERR1: HREADYOUT=0, HRESP=ERROR.
//     Then ST_ERR2: HREADYOUT=1, HRESP=ERROR. Then ST_IDLE.
//   * During ST_ERR2, a new address phase may be accepted (HREADY=1) and is processed
//     normally.
//   * Illegal accesses never touch the SRAM.
// - Write commit: at the edge that ends the completing data phase (HREADYOUT=1, OKAY).
//   * Byte lanes are little-endian: BYTE -> lane addr_q[1:0]; HALFWORD -> lanes
//     {addr_q[1],0}+{0,1}; WORD -> all four lanes.
//   * Data is taken from HWDATA's matching lanes. Other lanes are unchanged.
// - Read: HRDATA = full word mem[addr_q] combinationally, during the completing read
//   data phase. This makes write-then-read of the same address, back to back, return
//   the new data.
//   * HRDATA = 0 in every other cycle, including wait and error cycles.
// - Pipelining: a new address phase overlapping a completing data phase is accepted in
//   the same edge. Zero-wait back-to-back NONSEQ/SEQ gives one transfer per cycle.
// - While HREADYOUT=0, the slave ignores HTRANS/HADDR; the master holds them per
//   protocol.
// - Reset asserted mid-transfer: immediately ST_IDLE with the outputs at their reset
//   values. A pending write is discarded.
// STRUCTURE
// - Types come from master_package: HTRANS_E, HSIZE_E, HBURST_E, HRESP_E.
// - Add to master_package:
//   * SLV_STATE_E (ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2)
//   * a function size_to_strb(HSIZE_E, addr[1:0]) -> [3:0] byte-strobe mask
// - Sub-module ahb_sram_array: MEM_DEPTH x 32 storage.
//   * Ports: clk, we, strb[3:0], waddr, wdata, raddr, rdata.
//   * Per-byte write enable; asynchronous read.
// - Top holds the FSM, the wait counter, the address-phase registers and error decode.
// TESTING
// - Zero-wait WORD write 0xDEADBEEF @0x10, then READ @0x10:
//   HREADYOUT stays 1, OKAY, HRDATA=0xDEADBEEF in the read data phase.
// - BYTE writes 0x11@0x20, 0x22@0x21, HALFWORD 0x4433@0x22, then WORD read @0x20
//   -> 0x44332211.
// - WAIT_STATES=2, single read: exactly 2 cycles HREADYOUT=0, then 1 cycle HREADYOUT=1
//   with data. HRDATA=0 during the waits.
// - WORD access @0x02, and access @BASE+MEM_DEPTH*4:
//   ERR1 (HREADYOUT=0, ERROR) then ERR2 (HREADYOUT=1, ERROR). SRAM is unchanged
//   (read back).
// - INCR4 SEQ burst of words 1,2,3,4 @0x40, zero-wait: 4 consecutive OKAY cycles.
//   Readback burst returns 1,2,3,4. IDLE/BUSY beats get zero-wait OKAY.
// - HRESETn low during ST_WAIT of a write: HREADYOUT=1, OKAY, HRDATA=0 immediately.
//   Target word unchanged after release.

Source files
------------

// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite bus types and helpers used by the master and the SRAM responder.
package master_package;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } HTRANS_E;

  typedef enum logic [2:0] {
    BYTE     = 3'd0,
    HALFWORD = 3'd1,
    WORD     = 3'd2
  } HSIZE_E;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } HBURST_E;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } HRESP_E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } SLV_STATE_E;

  // Little-endian lane mask; unsupported sizes select no lanes.
  function automatic logic [3:0] size_to_strb(input HSIZE_E size, input logic [1:0] addr);
    logic [3:0] strb;
    strb = 4'b0000;
    case (size)
      BYTE:     strb = 4'b0001 << addr;
      HALFWORD: strb = addr[1] ? 4'b1100 : 4'b0011;
      WORD:     strb = 4'b1111;
      default:  strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between a master (or bench) and the SRAM responder.
interface ahb_sram_slave_if;
  import master_package::*;

  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  HSIZE_E      HSIZE;
  HBURST_E     HBURST;
  HTRANS_E     HTRANS;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  HRESP_E      HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM with per-byte write enables and asynchronous read.
module ahb_sram_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    strb,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder in front of a local SRAM: wait-state insertion, byte lanes,
// and two-cycle ERROR responses for misaligned, oversized or out-of-window accesses.
module ahb_sram_slave
  import master_package::*;
#(
  parameter int          MEM_DEPTH   = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  ahb_sram_slave_if.slave bus
);

  localparam int          AW     = $clog2(MEM_DEPTH);
  localparam logic [32:0] WINDOW = 33'(MEM_DEPTH) * 33'd4;

  SLV_STATE_E    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          dphase_q, dphase_d;
  logic [AW-1:0] addr_q;
  logic [1:0]    lane_q;
  logic          write_q;
  HSIZE_E        size_q;

  logic          accept;
  logic          illegal;
  logic [31:0]   offset;
  logic          rdy_c;
  HRESP_E        resp_c;
  logic          we;
  logic [3:0]    strb;
  logic [31:0]   rdata;
  logic          unused_ok;

  assign offset  = bus.HADDR - BASE_ADDR;
  assign accept  = bus.HSEL && bus.HREADY &&
                   (bus.HTRANS == NONSEQ || bus.HTRANS == SEQ) &&
                   (state_q == ST_IDLE || state_q == ST_ERR2);
  assign illegal = (bus.HADDR < BASE_ADDR) ||
                   ({1'b0, offset} >= WINDOW) ||
                   (bus.HSIZE > WORD) ||
                   (bus.HSIZE == HALFWORD && bus.HADDR[0]) ||
                   (bus.HSIZE == WORD && bus.HADDR[1:0] != 2'b00);

  // Control state: FSM, wait counter and the "a legal data phase is owned" flag.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      dphase_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dphase_q <= dphase_d;
    end
  end

  // Address-phase capture; only meaningful while dphase_q is set.
  always_ff @(posedge HCLK) begin
    if (accept) begin
      addr_q  <= offset[AW+1:2];
      lane_q  <= bus.HADDR[1:0];
      write_q <= bus.HWRITE;
      size_q  <= bus.HSIZE;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dphase_d = 1'b0;
    rdy_c    = 1'b1;
    resp_c   = OKAY;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (state_q == ST_ERR2) resp_c = ERROR;
        state_d = ST_IDLE;
        if (accept) begin
          if (illegal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            dphase_d = 1'b1;
          end else begin
            state_d  = ST_WAIT;
            cnt_d    = 4'(WAIT_STATES);
            dphase_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        rdy_c    = 1'b0;
        dphase_d = 1'b1;
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_IDLE;
      end
      ST_ERR1: begin
        rdy_c   = 1'b0;
        resp_c  = ERROR;
        state_d = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The completing data phase is ST_IDLE with a legal transfer pending.
  assign we   = (state_q == ST_IDLE) && dphase_q && write_q;
  assign strb = size_to_strb(size_q, lane_q);

  ahb_sram_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (HCLK),
    .we    (we),
    .strb  (strb),
    .waddr (addr_q),
    .wdata (bus.HWDATA),
    .raddr (addr_q),
    .rdata (rdata)
  );

  assign bus.HREADYOUT = rdy_c;
  assign bus.HRESP     = resp_c;
  assign bus.HRDATA    = ((state_q == ST_IDLE) && dphase_q && !write_q) ? rdata : 32'h0;

  assign unused_ok = ^{bus.HBURST, offset[31:AW+2], offset[1:0]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: zero-wait and two-wait-state responders sharing one stimulus bus.
module tb_ahb_sram_slave;
  import master_package::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel0, sel2;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  HSIZE_E      hsize;
  HBURST_E     hburst;
  HTRANS_E     htrans;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ahb_sram_slave_if bus0();
  ahb_sram_slave_if bus2();

  assign bus0.HSEL   = sel0;
  assign bus0.HADDR  = haddr;
  assign bus0.HWRITE = hwrite;
  assign bus0.HSIZE  = hsize;
  assign bus0.HBURST = hburst;
  assign bus0.HTRANS = htrans;
  assign bus0.HWDATA = hwdata;
  assign bus0.HREADY = bus0.HREADYOUT;

  assign bus2.HSEL   = sel2;
  assign bus2.HADDR  = haddr;
  assign bus2.HWRITE = hwrite;
  assign bus2.HSIZE  = hsize;
  assign bus2.HBURST = hburst;
  assign bus2.HTRANS = htrans;
  assign bus2.HWDATA = hwdata;
  assign bus2.HREADY = bus2.HREADYOUT;

  ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus0));

  ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut2 (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_ph(input logic s0, input logic s2, input HTRANS_E t, input logic w,
                         input HSIZE_E sz, input logic [31:0] a);
    sel0 = s0; sel2 = s2; htrans = t; hwrite = w; hsize = sz; haddr = a;
  endtask

  task automatic look0(input string tag, input logic rdy, input HRESP_E rsp, input logic [31:0] rd);
    @(negedge clk);
    chk({tag, ".rdy"},   32'(bus0.HREADYOUT), 32'(rdy));
    chk({tag, ".resp"},  32'(bus0.HRESP),     32'(rsp));
    chk({tag, ".rdata"}, bus0.HRDATA,         rd);
  endtask

  task automatic look2(input string tag, input logic rdy, input HRESP_E rsp, input logic [31:0] rd);
    @(negedge clk);
    chk({tag, ".rdy"},   32'(bus2.HREADYOUT), 32'(rdy));
    chk({tag, ".resp"},  32'(bus2.HRESP),     32'(rsp));
    chk({tag, ".rdata"}, bus2.HRDATA,         rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    hwdata = 32'h0;
    hburst = SINGLE;
    addr_ph(0, 0, IDLE, 0, WORD, 32'h0);

    look0("rst0", 1, OKAY, 32'h0);
    look2("rst2", 1, OKAY, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Zero-wait word write followed immediately by read of the same word
    addr_ph(1, 0, NONSEQ, 1, WORD, 32'h10);
    look0("t1a", 1, OKAY, 32'h0);
    step();
    hwdata = 32'hDEAD_BEEF;
    addr_ph(1, 0, NONSEQ, 0, WORD, 32'h10);
    look0("t1w", 1, OKAY, 32'h0);
    step();
    addr_ph(1, 0, IDLE, 0, WORD, 32'h10);
    look0("t1r", 1, OKAY, 32'hDEAD_BEEF);
    step();
    look0("t1i", 1, OKAY, 32'h0);

    // Byte and halfword lanes with junk in the unselected lanes
    addr_ph(1, 0, NONSEQ, 1, BYTE, 32'h20);
    step();
    hwdata = 32'hAAAA_AA11;
    addr_ph(1, 0, NONSEQ, 1, BYTE, 32'h21);
    step();
    hwdata = 32'hBBBB_22BB;
    addr_ph(1, 0, NONSEQ, 1, HALFWORD, 32'h22);
    step();
    hwdata = 32'h4433_CCCC;
    addr_ph(1, 0, NONSEQ, 0, WORD, 32'h20);
    look0("t2h", 1, OKAY, 32'h0);
    step();
    addr_ph(1, 0, NONSEQ, 1, BYTE, 32'h13);
    look0("t2r", 1, OKAY, 32'h4433_2211);
    step();
    hwdata = 32'h55EE_EEEE;
    addr_ph(1, 0, NONSEQ, 0, WORD, 32'h10);
    step();
    addr_ph(1, 0, IDLE, 0, WORD, 32'h10);
    look0("t2b", 1, OKAY, 32'h55AD_BEEF);
    step();

    // Illegal accesses: misaligned word, out of window, oversize, odd halfword
    addr_ph(1, 0, NONSEQ, 1, WORD, 32'h00);
    step();
    hwdata = 32'h0102_0304;
    addr_ph(1, 0, NONSEQ, 1, WORD, 32'h02);
    step();
    hwdata = 32'hFFFF_FFFF;
    addr_ph(1, 0, NONSEQ, 1, WORD, 32'h400);
    look0("t3e1", 0, ERROR, 32'h0);
    step();
    look0("t3e2", 1, ERROR, 32'h0);
    step();
    look0("t3f1", 0, ERROR, 32'h0);
    step();
    addr_ph(1, 0, NONSEQ, 1, HSIZE_E'(3'd3), 32'h00);
    look0("t3f2", 1, ERROR, 32'h0);
    step();
    look0("t3g1", 0, ERROR, 32'h0);
    step();
    addr_ph(1, 0, NONSEQ, 1, HALFWORD, 32'h01);
    look0("t3g2", 1, ERROR, 32'h0);
    step();
    look0("t3h1", 0, ERROR, 32'h0);
    step();
    addr_ph(1, 0, NONSEQ, 0, WORD, 32'h00);
    look0("t3h2", 1, ERROR, 32'h0);
    step();
    addr_ph(1, 0, IDLE, 0, WORD, 32'h00);
    look0("t3rd", 1, OKAY, 32'h0102_0304);
    step();

    // INCR4 write burst then readback burst with a BUSY beat
    hburst = INCR4;
    addr_ph(1, 0, NONSEQ, 1, WORD, 32'h40);
    step();
    for (int i = 0; i < 4; i++) begin
      hwdata = 32'(i + 1);
      if (i < 3) addr_ph(1, 0, SEQ, 1, WORD, 32'h44 + 32'(4 * i));
      else       addr_ph(1, 0, NONSEQ, 0, WORD, 32'h40);
      look0($sformatf("t4w%0d", i), 1, OKAY, 32'h0);
      step();
    end
    addr_ph(1, 0, SEQ, 0, WORD, 32'h44);
    look0("t4r0", 1, OKAY, 32'd1);
    step();
    addr_ph(1, 0, SEQ, 0, WORD, 32'h48);
    look0("t4r1", 1, OKAY, 32'd2);
    step();
    addr_ph(1, 0, BUSY, 0, WORD, 32'h4C);
    look0("t4r2", 1, OKAY, 32'd3);
    step();
    addr_ph(1, 0, SEQ, 0, WORD, 32'h4C);
    look0("t4busy", 1, OKAY, 32'h0);
    step();
    addr_ph(1, 0, IDLE, 0, WORD, 32'h4C);
    look0("t4r3", 1, OKAY, 32'd4);
    step();
    hburst = SINGLE;

    // Unselected NONSEQ write must not reach the SRAM
    addr_ph(0, 0, NONSEQ, 1, WORD, 32'h10);
    step();
    hwdata = 32'h0;
    addr_ph(1, 0, NONSEQ, 0, WORD, 32'h10);
    look0("t5ns", 1, OKAY, 32'h0);
    step();
    addr_ph(1, 0, IDLE, 0, WORD, 32'h10);
    look0("t5rd", 1, OKAY, 32'h55AD_BEEF);
    step();

    // Two wait states: write then read on the WAIT_STATES=2 responder
    addr_ph(0, 1, NONSEQ, 1, WORD, 32'h08);
    step();
    hwdata = 32'hCAFE_F00D;
    addr_ph(0, 1, NONSEQ, 0, WORD, 32'h08);
    look2("t6w0", 0, OKAY, 32'h0);
    step();
    look2("t6w1", 0, OKAY, 32'h0);
    step();
    look2("t6wd", 1, OKAY, 32'h0);
    step();
    addr_ph(0, 1, IDLE, 0, WORD, 32'h08);
    look2("t6r0", 0, OKAY, 32'h0);
    step();
    look2("t6r1", 0, OKAY, 32'h0);
    step();
    look2("t6rd", 1, OKAY, 32'hCAFE_F00D);
    step();
    look2("t6i", 1, OKAY, 32'h0);
    step();

    // Reset in the middle of a waited write discards it
    addr_ph(0, 1, NONSEQ, 1, WORD, 32'h08);
    step();
    hwdata = 32'h1234_5678;
    addr_ph(0, 1, IDLE, 0, WORD, 32'h08);
    look2("t7w", 0, OKAY, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t7rst.rdy",   32'(bus2.HREADYOUT), 32'd1);
    chk("t7rst.resp",  32'(bus2.HRESP),     32'(OKAY));
    chk("t7rst.rdata", bus2.HRDATA,         32'h0);
    step();
    step();
    rst_n = 1'b1;
    addr_ph(0, 1, NONSEQ, 0, WORD, 32'h08);
    step();
    addr_ph(0, 1, IDLE, 0, WORD, 32'h08);
    look2("t7a", 0, OKAY, 32'h0);
    step();
    look2("t7b", 0, OKAY, 32'h0);
    step();
    look2("t7rd", 1, OKAY, 32'hCAFE_F00D);
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
